// File: rtl/dual_input_debouncer.sv
// Two independent synchronise-and-debounce channels producing clean A/B levels.
// Define DEBOUNCER_EDGE_PULSE_EN to add one-cycle rising-edge pulses on APulse/BPulse.

module dual_input_debouncer_chan #(
  parameter int CNT_WIDTH    = 20,
  parameter int STABLE_COUNT = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic o_pulse
`endif
);
  // state       | meaning
  // S_LOW       | output 0, counter held at 0
  // S_WAIT_HIGH | output 0, counting cycles of synchronised 1
  // S_HIGH      | output 1, counter held at 0
  // S_WAIT_LOW  | output 1, counting cycles of synchronised 0
  typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 w_terminal;

  assign w_terminal = (r_cnt == TERMINAL);
  assign o_level    = r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      case (r_state)
        S_LOW: begin
          if (r_s2) begin
            r_state <= S_WAIT_HIGH;
            r_cnt   <= ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (!r_s2) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (w_terminal) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        S_HIGH: begin
          if (!r_s2) begin
            r_state <= S_WAIT_LOW;
            r_cnt   <= ONE;
          end
        end
        S_WAIT_LOW: begin
          if (r_s2) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (w_terminal) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic r_pulse;

  // Fires on the same edge that raises the level, so it coincides with the first cycle of 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= (r_state == S_WAIT_HIGH) && r_s2 && w_terminal;
    end
  end

  assign o_pulse = r_pulse;
`endif
endmodule

module dual_input_debouncer #(
  parameter int CNT_WIDTH    = 20,
  parameter int STABLE_COUNT = 1000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic RawA,
  input  logic RawB,
  output logic A,
  output logic B
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic APulse,
  output logic BPulse
`endif
);
  dual_input_debouncer_chan #(
    .CNT_WIDTH   (CNT_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_chan_a (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_raw  (RawA),
    .o_level(A)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .o_pulse(APulse)
`endif
  );

  dual_input_debouncer_chan #(
    .CNT_WIDTH   (CNT_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_chan_b (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_raw  (RawB),
    .o_level(B)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .o_pulse(BPulse)
`endif
  );
endmodule

// File: tb/tb_dual_input_debouncer.sv
// Scoreboard bench for dual_input_debouncer (STABLE_COUNT=8, so a clean step shows after 10 edges).
// Pulse outputs are checked only when DEBOUNCER_EDGE_PULSE_EN is defined.

module tb_dual_input_debouncer;
  logic Clk;
  logic Rst;
  logic RawA;
  logic RawB;
  logic A;
  logic B;
  logic APulse;
  logic BPulse;

  typedef struct {
    int    cyc;
    logic  a;
    logic  b;
    logic  ap;
    logic  bp;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  dual_input_debouncer #(
    .CNT_WIDTH   (4),
    .STABLE_COUNT(8)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .RawA  (RawA),
    .RawB  (RawB),
    .A     (A),
    .B     (B)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .APulse(APulse),
    .BPulse(BPulse)
`endif
  );

`ifndef DEBOUNCER_EDGE_PULSE_EN
  assign APulse = 1'b0;
  assign BPulse = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) edge_cnt++;

  // Monitor: pops every expectation due at the current edge and compares mid-cycle.
  always @(negedge Clk) begin
    exp_t e;
    logic bad;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e   = sb.pop_front();
      bad = (e.cyc != edge_cnt) || (A !== e.a) || (B !== e.b);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      bad = bad || (APulse !== e.ap) || (BPulse !== e.bp);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s edge=%0d (due %0d): got A=%b B=%b AP=%b BP=%b, expected A=%b B=%b AP=%b BP=%b",
                 e.nm, edge_cnt, e.cyc, A, B, APulse, BPulse, e.a, e.b, e.ap, e.bp);
      end
    end
  end

  task automatic step(input logic ra, input logic rb, input logic rst,
                      input logic ea, input logic eb, input logic pa, input logic pb,
                      input string nm);
    exp_t e;
    RawA = ra;
    RawB = rb;
    Rst  = rst;
    @(posedge Clk);
    #1;
    e.cyc = edge_cnt;
    e.a   = ea;
    e.b   = eb;
    e.ap  = pa;
    e.bp  = pb;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    Rst  = 1'b1;
    RawA = 1'b1;
    RawB = 1'b1;

    for (int i = 1; i <= 3; i++) step(1, 1, 1, 0, 0, 0, 0, "reset_hold");
    for (int i = 1; i <= 12; i++) step(1, 1, 0, i >= 10, i >= 10, i == 10, i == 10, "post_reset_rise");

    for (int i = 1; i <= 12; i++) step(0, 0, 0, i < 10, i < 10, 0, 0, "fall_both");

    for (int i = 1; i <= 12; i++) step(1, 0, 0, i >= 10, 0, i == 10, 0, "clean_step_a");

    for (int i = 1; i <= 12; i++) step(0, 0, 0, i < 10, 0, 0, 0, "drop_a_1");
    for (int seg = 0; seg < 4; seg++)
      for (int i = 1; i <= 3; i++) step((seg % 2) == 0, 0, 0, 0, 0, 0, 0, "bounce");
    for (int i = 1; i <= 12; i++) step(1, 0, 0, i >= 10, 0, i == 10, 0, "bounce_settle");

    for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, 0, 0, 0, "glitch_low");
    for (int i = 1; i <= 12; i++) step(1, 0, 0, 1, 0, 0, 0, "glitch_recover");

    for (int i = 1; i <= 12; i++) step(0, 0, 0, i < 10, 0, 0, 0, "drop_a_2");
    for (int i = 1; i <= 12; i++) step(1, 1, 0, i >= 10, i >= 10, i == 10, i == 10, "simul_rise");
    for (int i = 1; i <= 12; i++) step(1, 0, 0, 1, i < 10, 0, 0, "b_fall");

    for (int i = 1; i <= 7; i++) step(1, 1, 0, 1, 0, 0, 0, "b_midcount");
    for (int i = 1; i <= 2; i++) step(1, 1, 1, 0, 0, 0, 0, "reset_mid");
    for (int i = 1; i <= 12; i++) step(1, 1, 0, i >= 10, i >= 10, i == 10, i == 10, "post_mid_reset");

    @(negedge Clk);
    @(negedge Clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at edge %0d, expected bench to finish", edge_cnt);
    $fatal(1, "watchdog expired");
  end
endmodule
